// File: rtl/pfa_serial_adder_ctrl.sv
// Bit-serial N-bit adder sequencing one external PFA slice, LSB first.
// Latency: start accepted at edge k -> busy cycles k+1..k+N -> done pulse in cycle k+N+1.
// No backpressure: start is only sampled in IDLE; requests in RUN/DONE are dropped.
module pfa_serial_adder_ctrl #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         ovf,
    output logic         pfa_a,
    output logic         pfa_b,
    output logic         pfa_c,
    input  logic         pfa_s,
    input  logic         pfa_g,
    input  logic         pfa_p
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  areg;
    logic [N-1:0]  breg;
    logic [N-1:0]  sreg;
    logic [CW-1:0] cnt;
    logic          carry;
    logic          cmsb;

    logic          carry_nxt;
    logic [N-1:0]  sum_nxt;

    assign carry_nxt = pfa_g | (pfa_p & carry);
    assign sum_nxt   = {pfa_s, sreg[N-1:1]};

    // The PFA only sees live operand bits while running; it idles at zero otherwise.
    assign pfa_a = (state == RUN) & areg[0];
    assign pfa_b = (state == RUN) & breg[0];
    assign pfa_c = (state == RUN) & carry;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            areg  <= '0;
            breg  <= '0;
            sreg  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            cmsb  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sreg  <= sum_nxt;
                    carry <= carry_nxt;
                    areg  <= areg >> 1;
                    breg  <= breg >> 1;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB on this edge
                        cmsb  <= carry;
                        s     <= sum_nxt;
                        cout  <= carry_nxt;
                        ovf   <= carry ^ carry_nxt;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pfa_serial_adder_ctrl.sv
// Directed and randomized checks of the serial adder controller against an arithmetic reference.
module tb_pfa_serial_adder_ctrl;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [N-1:0] s;
    logic         pfa_a, pfa_b, pfa_c;
    logic         pfa_s, pfa_g, pfa_p;

    int ncmp  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    // Behavioural model of the external PFA cell
    assign pfa_s = pfa_a ^ pfa_b ^ pfa_c;
    assign pfa_g = pfa_a & pfa_b;
    assign pfa_p = pfa_a | pfa_b;

    pfa_serial_adder_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout),
        .ovf   (ovf),
        .pfa_a (pfa_a),
        .pfa_b (pfa_b),
        .pfa_c (pfa_c),
        .pfa_s (pfa_s),
        .pfa_g (pfa_g),
        .pfa_p (pfa_p)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Carry into bit j of ta+tb+tcin, from plain integer arithmetic
    function automatic logic carry_into(input int j, input int ta, input int tb, input int tcin);
        int m;
        m = (1 << j) - 1;
        return 1'(((ta & m) + (tb & m) + tcin) >> j);
    endfunction

    // Called #1 after an edge with the DUT in IDLE; returns #1 after the edge
    // that begins the IDLE cycle following DONE.
    task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tcin, input bit hold);
        logic [N:0]   full;
        logic         exp_ovf;
        full    = {1'b0, ta} + {1'b0, tb} + {{N{1'b0}}, tcin};
        exp_ovf = (ta[N-1] == tb[N-1]) && (full[N-1] != ta[N-1]);
        a = ta; b = tb; cin = tcin; start = 1'b1;
        for (int i = 1; i <= N + 2; i++) begin
            @(posedge clk); #1;
            if (hold) begin
                a = N'($urandom); b = N'($urandom); cin = 1'($urandom);
            end else if (i == 1) begin
                start = 1'b0;
            end
            chk("busy", busy, (i <= N));
            chk("done", done, (i == N + 1));
            if (i <= N) begin
                chk("pfa_a", pfa_a, ta[i-1]);
                chk("pfa_b", pfa_b, tb[i-1]);
                chk("pfa_c", pfa_c, carry_into(i - 1, int'(ta), int'(tb), int'(tcin)));
            end else begin
                chk("pfa_idle", {pfa_a, pfa_b, pfa_c}, 3'b000);
                chk("s", s, full[N-1:0]);
                chk("cout", cout, full[N]);
                chk("ovf", ovf, exp_ovf);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_cout_ovf", {cout, ovf}, 2'b00);
        chk("rst_pfa", {pfa_a, pfa_b, pfa_c}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h5A, 8'h3C, 1'b0, 0);
        chk("d1_s", s, 8'h96); chk("d1_cout", cout, 0); chk("d1_ovf", ovf, 1);

        run_op(8'hFF, 8'h01, 1'b0, 0);
        chk("d2_s", s, 8'h00); chk("d2_cout", cout, 1); chk("d2_ovf", ovf, 0);

        run_op(8'h7F, 8'h00, 1'b1, 0);
        chk("d3_s", s, 8'h80); chk("d3_cout", cout, 0); chk("d3_ovf", ovf, 1);

        run_op(8'h80, 8'h80, 1'b0, 0);
        chk("d4_s", s, 8'h00); chk("d4_cout", cout, 1); chk("d4_ovf", ovf, 1);

        // start held high with churning operands, then a back-to-back accept
        run_op(8'h33, 8'h44, 1'b1, 1);
        chk("hold_s", s, 8'h78);
        run_op(8'h10, 8'h20, 1'b0, 0);
        chk("b2b_s", s, 8'h30);

        // reset in the middle of a run
        a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_s", s, 0);
        chk("mrst_cout_ovf", {cout, ovf}, 2'b00);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("mrst_no_done", {busy, done}, 2'b00);
        end
        run_op(8'h01, 8'h01, 1'b0, 0);
        chk("post_rst_s", s, 8'h02);

        for (int n = 0; n < 1000; n++)
            run_op(N'($urandom), N'($urandom), 1'($urandom), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
